// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - attention-pass instruction sequencer driving the core inst word
module core_ctrl #(
    parameter int col   = 8,
    parameter int len   = 8,
    parameter int drain = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    output logic [31:0] inst,
    output logic        mem_req,
    output logic        mem_sel,
    output logic [3:0]  mem_addr,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_QWR   = 4'd1;
    localparam logic [3:0] S_KWR   = 4'd2;
    localparam logic [3:0] S_KLOAD = 4'd3;
    localparam logic [3:0] S_QEXE  = 4'd4;
    localparam logic [3:0] S_DRAIN = 4'd5;
    localparam logic [3:0] S_OFRD  = 4'd6;
    localparam logic [3:0] S_NORM  = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    logic [3:0]  state;
    logic [15:0] cnt;
    logic [15:0] last_cnt;
    logic [3:0]  addr;
    logic [31:0] inst_raw;
    logic        req_raw;
    logic        sel_raw;

    assign addr = cnt[3:0];

    // KLOAD and QEXE carry one extra tail cycle for the SRAM read latency
    always_comb begin
        last_cnt = 16'd0;
        case (state)
            S_QWR:   last_cnt = 16'(len - 1);
            S_KWR:   last_cnt = 16'(col - 1);
            S_KLOAD: last_cnt = 16'(col);
            S_QEXE:  last_cnt = 16'(len);
            S_DRAIN: last_cnt = 16'(drain - 1);
            S_OFRD:  last_cnt = 16'(len - 1);
            S_NORM:  last_cnt = 16'(len - 1);
            default: last_cnt = 16'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 16'd0;
        end else if (!hold) begin
            case (state)
                S_IDLE: begin
                    cnt <= 16'd0;
                    if (start)
                        state <= S_QWR;
                end
                S_QWR, S_KWR, S_KLOAD, S_QEXE, S_DRAIN, S_OFRD, S_NORM: begin
                    if (cnt == last_cnt) begin
                        cnt   <= 16'd0;
                        state <= state + 4'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

    always_comb begin
        inst_raw = 32'd0;
        req_raw  = 1'b0;
        sel_raw  = 1'b0;
        case (state)
            S_QWR: begin
                inst_raw[4]     = 1'b1;
                inst_raw[15:12] = addr;
                req_raw         = 1'b1;
            end
            S_KWR: begin
                inst_raw[2]     = 1'b1;
                inst_raw[15:12] = addr;
                req_raw         = 1'b1;
                sel_raw         = 1'b1;
            end
            S_KLOAD: begin
                inst_raw[6] = 1'b1;
                if (cnt < 16'(col)) begin
                    inst_raw[3]     = 1'b1;
                    inst_raw[15:12] = addr;
                end
            end
            S_QEXE: begin
                inst_raw[7] = 1'b1;
                if (cnt < 16'(len)) begin
                    inst_raw[5]     = 1'b1;
                    inst_raw[15:12] = addr;
                end
            end
            S_OFRD: begin
                inst_raw[16]   = 1'b1;
                inst_raw[0]    = 1'b1;
                inst_raw[18]   = 1'b1;
                inst_raw[11:8] = addr;
            end
            S_NORM: begin
                inst_raw[19]   = 1'b1;
                inst_raw[20]   = 1'b1;
                inst_raw[11:8] = addr;
            end
            default: begin
                inst_raw = 32'd0;
            end
        endcase
    end

    // hold bubbles every instruction output but leaves busy visible
    assign inst     = hold ? 32'd0 : inst_raw;
    assign mem_req  = req_raw & ~hold;
    assign mem_sel  = sel_raw & ~hold;
    assign mem_addr = mem_req ? inst[15:12] : 4'd0;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE) & ~hold;

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - randomized check of core_ctrl against a flat pass-schedule model
module tb_core_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        hold = 1'b0;

    logic [31:0] inst0, inst1;
    logic        req0, req1, sel0, sel1, busy0, busy1, done0, done1;
    logic [3:0]  addr0, addr1;

    core_ctrl #(.col(8), .len(8), .drain(16)) dut0 (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .inst(inst0), .mem_req(req0), .mem_sel(sel0), .mem_addr(addr0),
        .busy(busy0), .done(done0)
    );

    core_ctrl #(.col(4), .len(16), .drain(3)) dut1 (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .inst(inst1), .mem_req(req1), .mem_sel(sel1), .mem_addr(addr1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic        req;
        logic        sel;
        logic [3:0]  addr;
        logic        done;
    } ent_t;

    ent_t sched [2][0:255];
    int   slen [2];
    int   pos [2] = '{-1, -1};
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_done0 = 0, gap0 = 0;
    int   last_done1 = 0, gap1 = 0;

    task automatic push(input int d, input logic [31:0] w, input logic r, input logic s, input logic dn);
        sched[d][slen[d]] = '{inst: w, req: r, sel: s, addr: (r ? w[15:12] : 4'd0), done: dn};
        slen[d] = slen[d] + 1;
    endtask

    // one flat list of per-cycle words for a whole pass, DONE last
    task automatic build(input int d, input int l, input int c, input int dr);
        slen[d] = 0;
        for (int i = 0; i < l; i++) push(d, 32'h10 | (32'(i & 15) << 12), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < c; i++) push(d, 32'h04 | (32'(i & 15) << 12), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < c; i++) push(d, 32'h48 | (32'(i & 15) << 12), 1'b0, 1'b0, 1'b0);
        push(d, 32'h40, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < l; i++) push(d, 32'hA0 | (32'(i & 15) << 12), 1'b0, 1'b0, 1'b0);
        push(d, 32'h80, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < dr; i++) push(d, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < l; i++) push(d, 32'h0005_0001 | (32'(i & 15) << 8), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < l; i++) push(d, 32'h0018_0000 | (32'(i & 15) << 8), 1'b0, 1'b0, 1'b0);
        push(d, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pos[0] <= -1;
            pos[1] <= -1;
        end else begin
            cyc <= cyc + 1;
            for (int d = 0; d < 2; d++) begin
                if (!hold) begin
                    if (pos[d] < 0) begin
                        if (start) pos[d] <= 0;
                    end else if (pos[d] + 1 >= slen[d]) begin
                        pos[d] <= -1;
                    end else begin
                        pos[d] <= pos[d] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [39:0] act, exp;
        ent_t e;
        for (int d = 0; d < 2; d++) begin
            act = (d == 0) ? {inst0, req0, sel0, addr0, busy0, done0}
                           : {inst1, req1, sel1, addr1, busy1, done1};
            if (reset || pos[d] < 0) begin
                exp = 40'd0;
            end else if (hold) begin
                exp = {32'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
            end else begin
                e   = sched[d][pos[d]];
                exp = {e.inst, e.req, e.sel, e.addr, 1'b1, e.done};
            end
            n_checks = n_checks + 1;
            if (act !== exp) begin
                n_fail = n_fail + 1;
                $display("FAIL cycle_dut%0d t=%0t: got %h expected %h", d, $time, act, exp);
            end
        end
        if (done0) begin gap0 = cyc - last_done0; last_done0 = cyc; end
        if (done1) begin gap1 = cyc - last_done1; last_done1 = cyc; end
    end

    task automatic wait_idle();
        int k;
        start = 1'b0;
        hold  = 1'b0;
        k = 0;
        while ((busy0 || busy1) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("wait_idle_timeout", 64'(k >= 500), 64'd0);
    endtask

    task automatic run_pass(input bit hold_ofrd, output int lat);
        int cE, k;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cE = cyc;
        if (hold_ofrd) begin
            k = 0;
            while (inst0 !== 32'h0005_0401 && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            check("reach_ofrd4", 64'(k >= 200), 64'd0);
            hold = 1'b1;
            repeat (3) @(posedge clk);
            #1 hold = 1'b0;
        end
        k = 0;
        @(negedge clk);
        while (!done0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        lat = cyc - cE + 1;
    endtask

    initial begin
        int lat, k;
        build(0, 8, 8, 16);
        build(1, 16, 4, 3);

        check("sched0_len", 64'(slen[0]), 64'd67);
        check("sched1_len", 64'(slen[1]), 64'd78);
        check("sched0_kload0", 64'(sched[0][16].inst), 64'h48);
        check("sched0_kload_tail", 64'(sched[0][24].inst), 64'h40);
        check("sched0_qexe0", 64'(sched[0][25].inst), 64'hA0);
        check("sched0_qexe_tail", 64'(sched[0][33].inst), 64'h80);
        check("sched0_ofrd3", 64'(sched[0][53].inst), 64'h0005_0301);
        check("sched0_norm0", 64'(sched[0][58].inst), 64'h0018_0000);
        check("sched1_qwr15", 64'(sched[1][15].inst), 64'h0000_F010);
        check("sched1_kwr0", 64'(sched[1][16].inst), 64'h0000_0004);
        check("sched1_ofrd15", 64'(sched[1][60].inst), 64'h0005_0F01);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({inst0, req0, sel0, addr0, busy0, done0}), 64'd0);
        reset = 1'b0;

        wait_idle();
        run_pass(1'b0, lat);
        check("pass_latency", 64'(lat), 64'd67);

        wait_idle();
        run_pass(1'b1, lat);
        check("pass_latency_hold3", 64'(lat), 64'd70);

        // reset while dut0 is in KLOAD cnt=3
        wait_idle();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (inst0 !== 32'h0000_3048 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("reach_kload3", 64'(k >= 200), 64'd0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_dut0", 64'({inst0, req0, sel0, addr0, busy0, done0}), 64'd0);
        check("async_reset_dut1", 64'({inst1, req1, sel1, addr1, busy1, done1}), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", 64'(busy0), 64'd0);

        // start held high: back-to-back passes
        start = 1'b1;
        repeat (300) @(posedge clk);
        #1 start = 1'b0;
        check("b2b_gap_dut0", 64'(gap0), 64'd68);
        check("b2b_gap_dut1", 64'(gap1), 64'd79);

        wait_idle();
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 4) == 0);
        end
        wait_idle();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Instruction sequencer that drives the 32-bit `inst` word of one `core` for a full attention pass: Q/K SRAM fill, K weight load into the first MAC array, Q execute, output-FIFO drain into pmem with row-sum capture, then normalization. It sits between the fullchip top level and `core`. It owns every timing decision the testbench otherwise hand-codes. It is a Moore FSM with a step counter. Data for `mem_in` is supplied externally when `mem_req` is asserted.

## Interface
- `col`, 8: MAC columns; K vectors loaded per pass.
- `len`, 8: Q vectors per pass (1..16).
- `drain`, 16: idle cycles between last execute and first ofifo read (>=1).
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `hold`  in  1  freeze state/counter; forces `inst`=0 and `mem_req`=0 while high.
- `inst`  out  32  instruction word to `core`.
- `mem_req`  out  1  external data must present `mem_in` this cycle.
- `mem_sel`  out  1  0 = Q vector requested, 1 = K vector.
- `mem_addr`  out  4  vector index requested; equals `inst[15:12]`.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, QWR, KWR, KLOAD, QEXE, DRAIN, OFRD, NORM, DONE. Each state except IDLE/DONE has a fixed length N. Counter `cnt` runs 0..N-1, then the state advances and `cnt` clears.
- IDLE: `inst`=0. `start`=1 -> QWR.
- QWR (N=len): `inst[4]` qmem_wr=1, `inst[15:12]`=cnt, `mem_req`=1, `mem_sel`=0.
- KWR (N=col): `inst[2]` kmem_wr=1, `inst[15:12]`=cnt, `mem_req`=1, `mem_sel`=1.
- KLOAD (N=col+1): `inst[6]` load=1 on all cycles. `inst[3]` kmem_rd=1 and `inst[15:12]`=cnt for cnt<col. The last cycle is load only, which covers the 1-cycle SRAM read latency.
- QEXE (N=len+1): `inst[7]` execute=1 on all cycles. `inst[5]` qmem_rd=1 and `inst[15:12]`=cnt for cnt<len.
- DRAIN (N=drain): `inst`=0.
- OFRD (N=len): `inst[16]` ofifo_rd=1, `inst[0]` pmem_wr=1, `inst[18]` sum_fifo_wr=1, `inst[11:8]`=cnt.
- NORM (N=len): `inst[19]` sum_fifo_rd=1, `inst[20]` norm_execute=1, `inst[11:8]`=cnt.
- DONE (1 cycle): `done`=1, `inst`=0 -> IDLE.
- All `inst` bits not listed for the current state are 0. Bit 26 (pmem_load), bits 27–31 (mac2 and outmem) and bits 21/22 (vmem) are always 0 in this block.
- Address fields are 4-bit. `len`=16 wraps `cnt` 15->0 exactly at the state change; there is no overflow into another field.
- `mem_addr` = `inst[15:12]` when `mem_req`=1, otherwise 0.

## Timing
- Reset (async, immediate): state=IDLE, cnt=0. `inst`=0, `mem_req`=0, `mem_sel`=0, `mem_addr`=0, `busy`=0, `done`=0.
- Reset mid-pass aborts with no completion pulse. The first edge after deassert still sees IDLE.
- `start` sampled at edge E in IDLE -> QWR cnt=0 is visible from E until E+1. `busy` rises at E.
- `start` is ignored in every state but IDLE, including DONE. If `start` is held high, the next pass begins at the edge that leaves IDLE, one IDLE cycle after DONE.
- Outputs are decoded combinationally from the registered state/cnt. `hold` is the only input path to the outputs and is applied as a combinational AND-mask.
- `hold`=1: state and cnt do not change, and the outputs are 0 (bubble). `busy` stays 1. `done` is masked, but DONE is held until `hold` drops, so the pulse is never lost.
- `hold` in IDLE blocks `start`.
- Pass length without hold is len+col+(col+1)+(len+1)+drain+len+len cycles, plus 1 DONE cycle.
- Defaults: 8+8+9+9+16+8+8 = 66 cycles, then DONE in cycle 67 after the start edge.
- `mem_in` must be valid in the same cycle as `mem_req`, because the SRAM write occurs at that cycle's closing edge.

## Test plan
- Reset during KLOAD cnt=3 -> all outputs are 0 immediately. The first post-reset edge with `start`=0 stays in IDLE.
- Default params, single `start` pulse -> exactly 8 `mem_req` cycles with sel=0 and addr 0..7, then 8 with sel=1, then `inst`=32'h48 (load+kmem_rd) with addr 0..7, then 32'h40 for one cycle. `done` appears 67 cycles after the start edge.
- Check the QEXE and OFRD words: QEXE shows `inst`=32'h0000_00A0|addr<<12 for 8 cycles, then 32'h80. OFRD shows 32'h0005_0001|cnt<<8 for cnt=0..7. NORM shows 32'h0018_0000|cnt<<8.
- `hold` high for 3 cycles in the middle of OFRD at cnt=4 -> 3 zero words, then cnt=4 resumes. There is no duplicated or skipped pmem address, and the total pass length grows by 3.
- `start` held constantly high -> back-to-back passes separated by exactly DONE plus 1 IDLE cycle. A `start` pulse while `busy` is ignored.
- `len`=16 -> QWR addresses 0..15, then KWR starts at 0. OFRD `inst[11:8]` covers 0..15 with no carry into bit 12.
